pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It complements the forwarding logic by generating every stall, flush and bubble the forwarding paths cannot resolve: the load-use bubble, the taken-branch/jump flush, and a multi-cycle hold while a multiply/divide unit in Execute completes a start/done handshake. It also keeps a saturating stall-cycle performance counter and a sticky timeout flag for the multi-cycle unit.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum MD_BUSY cycles before forced release; legal range 2..65535.
- `CW`, 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst == 0` resets on the next rising edge).
- `MemReadE`  in  1  Execute-stage instruction is a load.
- `RD_E`  in  5  Execute-stage destination register.
- `Rs1_D`, `Rs2_D`  in  5 each  Decode-stage source registers.
- `PCSrcE`  in  1  branch taken or jump resolved in Execute.
- `MulDivE`  in  1  Execute-stage instruction is a multi-cycle mul/div op.
- `MulDivDone`  in  1  single-cycle pulse from the unit; result valid this cycle.
- `StallF`, `StallD`, `StallE`  out  1 each  hold the corresponding pipeline register.
- `FlushD`, `FlushE`, `FlushM`  out  1 each  load a bubble into the corresponding pipeline register.
- `MulDivStart`  out  1  one-cycle start pulse to the unit.
- `MdTimeout`  out  1  sticky: the unit failed to answer within `TIMEOUT` cycles.
- `StallCycles`  out  CW  saturating count of cycles with `StallF == 1`.

## Operation
- FSM states:
  - RUN (reset state).
  - MD_BUSY.
- `lu` = `MemReadE & (RD_E != 0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D))`.
- All control outputs are combinational from the state and inputs. They are forced to 0 while `rst == 0`.
- RUN, priority high to low:
  1. `PCSrcE`: `FlushD = FlushE = 1`, no stall. This overrides `lu` because the Decode instruction is on the wrong path.
  2. `MulDivE`: `MulDivStart = 1`, `StallF = StallD = StallE = 1`, `FlushM = 1`. Next state is MD_BUSY and the busy counter clears to 0.
  3. `lu`: `StallF = StallD = 1`, `FlushE = 1`. This is a one-cycle bubble and the state stays RUN.
  4. Otherwise all outputs are 0.
- MD_BUSY:
  - If `MulDivDone = 1`: all stall/flush outputs are 0, so the instruction advances to Memory with the result. Next state is RUN.
  - Else if busy counter == `TIMEOUT-1`: stalls are 0, `FlushE = 1` drops the op, `MdTimeout` is set. Next state is RUN.
  - Else: `StallF = StallD = StallE = 1`, `FlushM = 1`, and the busy counter increments.
  - `lu` and `PCSrcE` are ignored in MD_BUSY. Execute holds the mul/div op, so `FlushE` must never kill it.
- `MulDivDone` asserted in RUN is ignored; it is a protocol error with no effect.
- `MulDivE & PCSrcE` together is illegal. If it occurs, `PCSrcE` wins.
- `StallCycles` increments by 1 in every cycle with `StallF = 1` and saturates at 2^CW−1, with no wrap.
- `MdTimeout` clears only on reset.
- Busy counter is a `$clog2(TIMEOUT)`-bit count of MD_BUSY cycles.

## Timing
- Reset values (outputs during and after reset):
  - All stall, flush and `MulDivStart` outputs are 0.
  - `StallCycles = 0`, `MdTimeout = 0`, state = RUN.
- Load-use: exactly 1 stall cycle, asserted in the same cycle as `lu`.
- Multi-cycle op with done on the N-th MD_BUSY cycle (N ≥ 1):
  - Execute is held for N cycles in total: the start cycle plus N−1 busy cycles.
  - `MulDivStart` is high for exactly 1 cycle.
- Timeout: the release cycle is the `TIMEOUT`-th MD_BUSY cycle.
- `rst` low mid-operation: from the next edge the state is RUN, counters and flag are 0, and no start pulse is reissued.
- Branch flush takes effect in the same cycle as `PCSrcE`; there is no added latency.

## Test plan
- **Load-use bubble.** Stimulus: `MemReadE=1`, `RD_E=5`, `Rs2_D=5` for 1 cycle. Response:
  - `StallF=StallD=FlushE=1` for that cycle only.
  - `StallCycles` goes 0→1.
  - The same stimulus with `RD_E=0` gives all outputs 0.
- **Branch over load-use.** Stimulus: `PCSrcE=1` with the load-use condition also true. Response:
  - `FlushD=FlushE=1`, `StallF=0`.
  - `StallCycles` unchanged.
- **Mul/div, done on 4th busy cycle.** Response:
  - `MulDivStart=1` for 1 cycle.
  - `StallE=FlushM=1` for 4 cycles, all 0 in the done cycle.
  - `StallCycles=4`, state returns to RUN.
- **Load-use during MD_BUSY.** Response: `FlushE` stays 0 throughout, and the stalls match the previous scenario.
- **Timeout.** `TIMEOUT=8`, no done. Response:
  - Stalls high for 8 cycles (start + 7 busy), then a release cycle with `FlushE=1`.
  - `MdTimeout=1` and stays 1 until `rst=0`.
  - A later `MulDivDone` in RUN has no effect.
- **Saturation and mid-op reset.**
  - `CW=3`: 10 consecutive stall cycles → `StallCycles` holds at 7.
  - `rst=0` during MD_BUSY → next edge state is RUN, all outputs and counters are 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush/bubble sequencing for the 5-stage core: load-use bubble, branch flush and
// multi-cycle mul/div hold with timeout, plus a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          MemReadE,
   input  logic [4:0]    RD_E,
   input  logic [4:0]    Rs1_D,
   input  logic [4:0]    Rs2_D,
   input  logic          PCSrcE,
   input  logic          MulDivE,
   input  logic          MulDivDone,
   output logic          StallF,
   output logic          StallD,
   output logic          StallE,
   output logic          FlushD,
   output logic          FlushE,
   output logic          FlushM,
   output logic          MulDivStart,
   output logic          MdTimeout,
   output logic [CW-1:0] StallCycles
);

   localparam int unsigned BW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BW-1:0] BusyLast = BW'(TIMEOUT - 1);

   typedef enum logic [0:0] {StRun, StMdBusy} state_e;

   state_e          state_q, state_d;
   logic [BW-1:0]   busy_q, busy_d;
   logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
   logic            md_timeout_q, md_timeout_d;
   logic            lu;

   assign lu = MemReadE & (RD_E != 5'd0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));

   always_comb begin
      StallF       = 1'b0;
      StallD       = 1'b0;
      StallE       = 1'b0;
      FlushD       = 1'b0;
      FlushE       = 1'b0;
      FlushM       = 1'b0;
      MulDivStart  = 1'b0;
      state_d      = state_q;
      busy_d       = busy_q;
      md_timeout_d = md_timeout_q;
      // All control outputs stay low while reset is held.
      if (rst) begin
         case (state_q)
            StRun: begin
               if (PCSrcE) begin
                  FlushD = 1'b1;
                  FlushE = 1'b1;
               end else if (MulDivE) begin
                  MulDivStart = 1'b1;
                  StallF      = 1'b1;
                  StallD      = 1'b1;
                  StallE      = 1'b1;
                  FlushM      = 1'b1;
                  state_d     = StMdBusy;
                  busy_d      = '0;
               end else if (lu) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
               end
            end
            StMdBusy: begin
               // Load-use and branch requests are ignored; Execute owns the mul/div op.
               if (MulDivDone) begin
                  state_d = StRun;
               end else if (busy_q == BusyLast) begin
                  FlushE       = 1'b1;
                  md_timeout_d = 1'b1;
                  state_d      = StRun;
               end else begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  StallE = 1'b1;
                  FlushM = 1'b1;
                  busy_d = busy_q + BW'(1);
               end
            end
            default: state_d = StRun;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (StallF && (stall_cnt_q != {CW{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StRun;
         busy_q       <= '0;
         stall_cnt_q  <= '0;
         md_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         stall_cnt_q  <= stall_cnt_d;
         md_timeout_q <= md_timeout_d;
      end
   end

   assign MdTimeout   = md_timeout_q & rst;
   assign StallCycles = rst ? stall_cnt_q : '0;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (TIMEOUT=8, CW=3).
module tb_pipeline_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       MemReadE;
   logic [4:0] RD_E, Rs1_D, Rs2_D;
   logic       PCSrcE, MulDivE, MulDivDone;
   logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivStart, MdTimeout;
   logic [2:0] StallCycles;
   logic [6:0] ctrl;

   int checks = 0;
   int errors = 0;

   // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivStart}
   localparam logic [6:0] CNone = 7'b0000000;
   localparam logic [6:0] CLu   = 7'b1100100;
   localparam logic [6:0] CBr   = 7'b0001100;
   localparam logic [6:0] CMds  = 7'b1110011;
   localparam logic [6:0] CMdb  = 7'b1110010;
   localparam logic [6:0] CTo   = 7'b0000100;

   pipeline_stall_ctrl #(.TIMEOUT(8), .CW(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .MemReadE    (MemReadE),
      .RD_E        (RD_E),
      .Rs1_D       (Rs1_D),
      .Rs2_D       (Rs2_D),
      .PCSrcE      (PCSrcE),
      .MulDivE     (MulDivE),
      .MulDivDone  (MulDivDone),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .FlushM      (FlushM),
      .MulDivStart (MulDivStart),
      .MdTimeout   (MdTimeout),
      .StallCycles (StallCycles)
   );

   assign ctrl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivStart};

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic r, input logic mr, input logic [4:0] rde,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic pc, input logic md, input logic done);
      @(negedge clk);
      rst        = r;
      MemReadE   = mr;
      RD_E       = rde;
      Rs1_D      = rs1;
      Rs2_D      = rs2;
      PCSrcE     = pc;
      MulDivE    = md;
      MulDivDone = done;
      #1;
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic lu_cycle();
      drive(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset, including a mul/div request that must be masked.
      do_reset();
      check_eq("rst_ctrl", 32'(ctrl), 32'(CNone));
      drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0);
      check_eq("rst_masked", 32'(ctrl), 32'(CNone));
      check_eq("rst_cnt", 32'(StallCycles), 0);
      check_eq("rst_to", 32'(MdTimeout), 0);

      // Load-use bubble.
      lu_cycle();
      check_eq("lu_ctrl", 32'(ctrl), 32'(CLu));
      check_eq("lu_cnt0", 32'(StallCycles), 0);
      idle();
      check_eq("lu_after", 32'(ctrl), 32'(CNone));
      check_eq("lu_cnt1", 32'(StallCycles), 1);
      drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_eq("lu_x0", 32'(ctrl), 32'(CNone));
      drive(1'b1, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0);
      check_eq("lu_rs1", 32'(ctrl), 32'(CLu));
      idle();
      check_eq("lu_cnt2", 32'(StallCycles), 2);

      // Branch over load-use.
      drive(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0);
      check_eq("br_ctrl", 32'(ctrl), 32'(CBr));
      idle();
      check_eq("br_cnt", 32'(StallCycles), 2);

      // Mul/div, done on 4th busy cycle; MulDivDone in RUN ignored.
      do_reset();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      check_eq("done_run", 32'(ctrl), 32'(CNone));
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check_eq("md_start", 32'(ctrl), 32'(CMds));
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
         check_eq($sformatf("md_busy%0d", i), 32'(ctrl), 32'(CMdb));
      end
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      check_eq("md_done", 32'(ctrl), 32'(CNone));
      lu_cycle();
      check_eq("md_run", 32'(ctrl), 32'(CLu));
      check_eq("md_cnt", 32'(StallCycles), 4);

      // Load-use and branch during MD_BUSY are ignored.
      do_reset();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check_eq("mdl_start", 32'(ctrl), 32'(CMds));
      drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
      check_eq("mdl_busy1", 32'(ctrl), 32'(CMdb));
      drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      check_eq("mdl_busy2", 32'(ctrl), 32'(CMdb));
      drive(1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0);
      check_eq("mdl_busy3", 32'(ctrl), 32'(CMdb));
      drive(1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1);
      check_eq("mdl_done", 32'(ctrl), 32'(CNone));
      idle();
      check_eq("mdl_cnt", 32'(StallCycles), 4);

      // Timeout: start + 7 busy stall cycles, release on the 8th busy cycle.
      do_reset();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check_eq("to_start", 32'(ctrl), 32'(CMds));
      for (int i = 1; i <= 7; i++) begin
         drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
         check_eq($sformatf("to_busy%0d", i), 32'(ctrl), 32'(CMdb));
         check_eq($sformatf("to_flag%0d", i), 32'(MdTimeout), 0);
      end
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check_eq("to_release", 32'(ctrl), 32'(CTo));
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      check_eq("to_done_run", 32'(ctrl), 32'(CNone));
      check_eq("to_flag", 32'(MdTimeout), 1);
      check_eq("to_cnt_sat", 32'(StallCycles), 7);
      idle();
      idle();
      check_eq("to_sticky", 32'(MdTimeout), 1);

      // Saturation with consecutive load-use stalls.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         lu_cycle();
         check_eq($sformatf("sat_cnt%0d", i), 32'(StallCycles), (i < 7) ? i : 7);
      end
      idle();
      check_eq("sat_final", 32'(StallCycles), 7);

      // Reset in the middle of MD_BUSY.
      do_reset();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check_eq("mid_busy", 32'(ctrl), 32'(CMdb));
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check_eq("mid_rst_ctrl", 32'(ctrl), 32'(CNone));
      idle();
      check_eq("mid_ctrl", 32'(ctrl), 32'(CNone));
      check_eq("mid_cnt", 32'(StallCycles), 0);
      check_eq("mid_to", 32'(MdTimeout), 0);
      lu_cycle();
      check_eq("mid_run", 32'(ctrl), 32'(CLu));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
